mem_fill_arbiter: RTL and testbench

- Shares the single pipelined main-memory port between three requesters: I-cache miss fill, D-cache miss fill and D-cache write-through.
- Sequences each 8-word block fill and returns words to the owning cache.
- Drives the pipeline-wide stall that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB buffers while memory is busy.
- Sits between the two caches and the memory model, inside the CPU top.

---
 rtl/mem_fill_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Purpose: arbitrates the single main-memory port between D write-through, D fill and I fill; sequences block fills and drives stall.
// Latency: first read issued on the cycle after grant, one address per cycle; fill_we one cycle after each mem_data_valid.
// Backpressure: requests are held until their done pulse; losers wait in IDLE arbitration. Optional MEM_FILL_PERF_CNT_EN adds counters.
module mem_fill_arbiter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_miss,
  input  logic [ADDR_W-1:0]                i_miss_addr,
  input  logic                             d_miss,
  input  logic [ADDR_W-1:0]                d_miss_addr,
  input  logic                             d_wr_req,
  input  logic [ADDR_W-1:0]                d_wr_addr,
  input  logic [15:0]                      d_wr_data,
  input  logic                             mem_data_valid,
  input  logic [15:0]                      mem_data_in,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [15:0]                      mem_wdata,
  output logic [15:0]                      fill_data,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
  output logic                             i_fill_we,
  output logic                             d_fill_we,
  output logic                             i_fill_done,
  output logic                             d_fill_done,
  output logic                             d_wr_done,
  output logic                             stall
`ifdef MEM_FILL_PERF_CNT_EN
  ,
  output logic [15:0]                      i_fill_cnt,
  output logic [15:0]                      d_fill_cnt,
  output logic [15:0]                      wr_cnt
`endif
);

  localparam int WW = $clog2(WORDS_PER_BLK);
  localparam int BW = ADDR_W - WW - 1;
  localparam logic [WW-1:0] LAST_W = WW'(WORDS_PER_BLK - 1);

  typedef enum logic [2:0] {IDLE, WRITE, FILL_I, FILL_D, DONE} state_t;
  typedef enum logic [1:0] {OWN_WR, OWN_D, OWN_I} own_t;

  state_t            state_q, state_d;
  own_t              own_q, own_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic [WW-1:0]     ic_q, ic_d;
  logic [WW-1:0]     rc_q, rc_d;
  logic              iss_q, iss_d;
  logic              pend_other;

  logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d, fill_data_q, fill_data_d;
  logic [WW-1:0]     fill_word_q, fill_word_d;
  logic              i_we_q, i_we_d, d_we_q, d_we_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d, wr_done_q, wr_done_d;
  logic              stall_q, stall_d;

  // Word-offset bits of miss addresses are irrelevant: fills always start at word 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[WW:0], d_miss_addr[WW:0]};

  // Arbitration, issue/return sequencing and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    blk_d       = blk_q;
    ic_d        = ic_q;
    rc_d        = rc_q;
    iss_d       = iss_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    fill_data_d = fill_data_q;
    fill_word_d = fill_word_q;
    i_we_d      = 1'b0;
    d_we_d      = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The D side holds the older instruction, so it wins over the I side.
        if (d_wr_req) begin
          state_d     = WRITE;
          own_d       = OWN_WR;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = d_wr_addr;
          mem_wdata_d = d_wr_data;
        end else if (d_miss) begin
          state_d    = FILL_D;
          own_d      = OWN_D;
          blk_d      = d_miss_addr[ADDR_W-1:WW+1];
          mem_en_d   = 1'b1;
          mem_addr_d = {d_miss_addr[ADDR_W-1:WW+1], {WW{1'b0}}, 1'b0};
          ic_d       = WW'(1);
          iss_d      = 1'b1;
          rc_d       = '0;
        end else if (i_miss) begin
          state_d    = FILL_I;
          own_d      = OWN_I;
          blk_d      = i_miss_addr[ADDR_W-1:WW+1];
          mem_en_d   = 1'b1;
          mem_addr_d = {i_miss_addr[ADDR_W-1:WW+1], {WW{1'b0}}, 1'b0};
          ic_d       = WW'(1);
          iss_d      = 1'b1;
          rc_d       = '0;
        end
      end
      WRITE: begin
        state_d   = DONE;
        wr_done_d = 1'b1;
      end
      FILL_I, FILL_D: begin
        if (iss_q) begin
          mem_en_d   = 1'b1;
          mem_addr_d = {blk_q, ic_q, 1'b0};
          ic_d       = ic_q + WW'(1);
          if (ic_q == LAST_W) iss_d = 1'b0;
        end
        if (mem_data_valid) begin
          fill_data_d = mem_data_in;
          fill_word_d = rc_q;
          i_we_d      = (state_q == FILL_I);
          d_we_d      = (state_q == FILL_D);
          rc_d        = rc_q + WW'(1);
          // Done pulse lands together with the final word's write enable.
          if (rc_q == LAST_W) begin
            state_d  = DONE;
            i_done_d = (state_q == FILL_I);
            d_done_d = (state_q == FILL_D);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The finishing requester still holds its line during DONE, so only other requesters keep stall up.
    case (own_q)
      OWN_WR:  pend_other = d_miss | i_miss;
      OWN_D:   pend_other = d_wr_req | i_miss;
      default: pend_other = d_wr_req | d_miss;
    endcase
    stall_d = (state_d != IDLE) || ((state_q == DONE) && pend_other);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      own_q       <= OWN_WR;
      blk_q       <= '0;
      ic_q        <= '0;
      rc_q        <= '0;
      iss_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_data_q <= '0;
      fill_word_q <= '0;
      i_we_q      <= 1'b0;
      d_we_q      <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      blk_q       <= blk_d;
      ic_q        <= ic_d;
      rc_q        <= rc_d;
      iss_q       <= iss_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_data_q <= fill_data_d;
      fill_word_q <= fill_word_d;
      i_we_q      <= i_we_d;
      d_we_q      <= d_we_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      wr_done_q   <= wr_done_d;
      stall_q     <= stall_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fill_data   = fill_data_q;
  assign fill_word   = fill_word_q;
  assign i_fill_we   = i_we_q;
  assign d_fill_we   = d_we_q;
  assign i_fill_done = i_done_q;
  assign d_fill_done = d_done_q;
  assign d_wr_done   = wr_done_q;
  assign stall       = stall_q;

`ifdef MEM_FILL_PERF_CNT_EN
  logic [15:0] i_cnt_q, d_cnt_q, w_cnt_q;

  // Saturating completion counters, bumped on each done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      w_cnt_q <= '0;
    end else begin
      if (i_done_q && (i_cnt_q != 16'hFFFF)) i_cnt_q <= i_cnt_q + 16'd1;
      if (d_done_q && (d_cnt_q != 16'hFFFF)) d_cnt_q <= d_cnt_q + 16'd1;
      if (wr_done_q && (w_cnt_q != 16'hFFFF)) w_cnt_q <= w_cnt_q + 16'd1;
    end
  end

  assign i_fill_cnt = i_cnt_q;
  assign d_fill_cnt = d_cnt_q;
  assign wr_cnt     = w_cnt_q;
`endif

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: a latency-programmable memory model plus a scoreboard of expected
// memory accesses and returned words, built from the priority and block-fill rules.
// A monitor compares every mem_en / fill_we / done event against the queues.
module tb_mem_fill_arbiter;
  localparam int WPB = 8;

  logic        clk;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, stall;
`ifdef MEM_FILL_PERF_CNT_EN
  logic [15:0] i_fill_cnt, d_fill_cnt, wr_cnt;
`endif

  mem_fill_arbiter #(.WORDS_PER_BLK(WPB), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .stall(stall)
`ifdef MEM_FILL_PERF_CNT_EN
    , .i_fill_cnt(i_fill_cnt), .d_fill_cnt(d_fill_cnt), .wr_cnt(wr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; int word; } mexp_t;
  typedef struct { logic is_i; logic [2:0] word; logic [15:0] data; logic last; } fexp_t;
  typedef struct { int due; logic [15:0] data; } mret_t;

  mexp_t exp_mem[$];
  fexp_t exp_fill[$];
  mret_t mq[$];
  int    checks = 0;
  int    errors = 0;
  int    lat = 3;
  bit    stray = 0;
  int    cyc = 0;
  int    mcyc = 0;
  int    wr_issued = 0;
  int    exp_icnt = 0, exp_dcnt = 0, exp_wcnt = 0;

  function automatic logic [15:0] memw(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of a block fill: 8 gapless reads from word 0, words returned in order.
  task automatic push_fill(input logic is_i, input logic [15:0] a);
    logic [15:0] blk;
    blk = a & 16'hFFF0;
    for (int w = 0; w < WPB; w++) begin
      mexp_t m;
      fexp_t f;
      logic [15:0] wa;
      wa = blk | 16'(w * 2);
      m.wr = 1'b0; m.addr = wa; m.wdata = 16'h0; m.word = w;
      exp_mem.push_back(m);
      f.is_i = is_i; f.word = 3'(w); f.data = memw(wa); f.last = (w == WPB - 1);
      exp_fill.push_back(f);
    end
  endtask

  task automatic start_i(input logic [15:0] a);
    i_miss_addr = a; i_miss = 1'b1;
    push_fill(1'b1, a);
    exp_icnt++;
  endtask

  task automatic start_d(input logic [15:0] a);
    d_miss_addr = a; d_miss = 1'b1;
    push_fill(1'b0, a);
    exp_dcnt++;
  endtask

  task automatic start_w(input logic [15:0] a, input logic [15:0] d);
    mexp_t m;
    d_wr_addr = a; d_wr_data = d; d_wr_req = 1'b1;
    m.wr = 1'b1; m.addr = a; m.wdata = d; m.word = -1;
    exp_mem.push_back(m);
    exp_wcnt++;
  endtask

  // Requesters drop their line on their done pulse; stall must hold until all are served.
  task automatic drain(input string name);
    int budget;
    int gaps;
    budget = 3000;
    gaps = 0;
    while ((d_wr_req | d_miss | i_miss) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (!stall) gaps++;
      if (d_wr_done) d_wr_req = 1'b0;
      if (d_fill_done) d_miss = 1'b0;
      if (i_fill_done) i_miss = 1'b0;
    end
    chk({name, "_timeout"}, 64'({d_wr_req, d_miss, i_miss}), 64'd0);
    chk({name, "_stall_held"}, 64'(gaps), 64'd0);
    @(negedge clk);
    chk({name, "_stall_release"}, 64'(stall), 64'd0);
    chk({name, "_all_consumed"}, 64'(exp_mem.size() + exp_fill.size() + wr_issued), 64'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                   i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, stall}), 64'd0);
  endtask

  task automatic wait_mem_empty();
    int b;
    b = 0;
    while (mq.size() > 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("mem_drained", 64'(mq.size()), 64'd0);
  endtask

  // Memory model: reads answered in order after 'lat' cycles; optional stray valids.
  initial begin
    mret_t r;
    mem_data_valid = 1'b0;
    mem_data_in = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_data_valid = 1'b0;
      mem_data_in = 16'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        mem_data_valid = 1'b1;
        mem_data_in = r.data;
      end else if (stray) begin
        mem_data_valid = 1'b1;
        mem_data_in = 16'($urandom);
      end
      if (mem_en && !mem_wr) begin
        r.due = cyc + lat;
        r.data = memw(mem_addr);
        mq.push_back(r);
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents an access, a word or a done pulse.
  initial begin
    mexp_t m;
    fexp_t f;
    int last_iss;
    int last_wr;
    last_iss = 0;
    last_wr = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (mem_en) begin
        chk("stall_during_access", 64'(stall), 64'd1);
        if (exp_mem.size() == 0) chk("mem_en_unexpected", 64'(mem_en), 64'd0);
        else begin
          m = exp_mem.pop_front();
          chk("mem_access", 64'({mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0}),
              64'({m.wr, m.addr, m.wdata}));
          if (!m.wr && m.word > 0) chk("issue_gapless", 64'(mcyc - last_iss), 64'd1);
          if (!m.wr) last_iss = mcyc;
          if (m.wr) begin
            wr_issued++;
            last_wr = mcyc;
          end
        end
      end
      if (i_fill_we | d_fill_we) begin
        chk("stall_during_fill", 64'(stall), 64'd1);
        if (exp_fill.size() == 0) chk("fill_we_unexpected", 64'({i_fill_we, d_fill_we}), 64'd0);
        else begin
          f = exp_fill.pop_front();
          chk("fill_event",
              64'({i_fill_we, d_fill_we, fill_word, fill_data, i_fill_done, d_fill_done}),
              64'({f.is_i, !f.is_i, f.word, f.data, f.last & f.is_i, f.last & !f.is_i}));
        end
      end else if (i_fill_done | d_fill_done) begin
        chk("orphan_fill_done", 64'({i_fill_done, d_fill_done}), 64'd0);
      end
      if (d_wr_done) begin
        if (wr_issued == 0) chk("wr_done_unexpected", 64'(d_wr_done), 64'd0);
        else begin
          chk("wr_done_timing", 64'(mcyc - last_wr), 64'd1);
          wr_issued--;
        end
      end
    end
  end

  initial begin
    bit seen;
    int we_seen;
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    lat = 4;
    start_i(16'h1236);
    drain("i_fill_lat4");

    lat = 2;
    start_d(16'h0040);
    start_i(16'h8000);
    drain("d_then_i");

    lat = 3;
    start_w(16'h00A2, 16'hBEEF);
    start_i(16'h4C10);
    drain("wr_then_i");

    lat = 5;
    start_i(16'h2A04);
    repeat (4) @(negedge clk);
    start_w(16'h7706, 16'h1234);
    drain("late_write");

    // Reset after the third returned word of a D fill.
    lat = 2;
    start_d(16'h3350);
    seen = 1'b0;
    for (int b = 0; b < 100 && !seen; b++) begin
      @(negedge clk);
      if (d_fill_we && fill_word == 3'd2) seen = 1'b1;
    end
    chk("rst_trigger_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    d_miss = 1'b0;
    @(posedge clk);
    #1;
    exp_mem.delete();
    exp_fill.delete();
    wr_issued = 0;
    exp_icnt = 0; exp_dcnt = 0; exp_wcnt = 0;
    @(negedge clk);
    check_zero_outputs("reset_midfill");
    rst = 1'b0;
    we_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (i_fill_we | d_fill_we) we_seen++;
    end
    chk("no_fill_after_rst", 64'(we_seen), 64'd0);
    wait_mem_empty();
    chk("idle_after_rst_stall", 64'(stall), 64'd0);

    // Stray valids while idle.
    stray = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_no_we", 64'({i_fill_we, d_fill_we}), 64'd0);
      chk("stray_stall", 64'(stall), 64'd0);
    end
    stray = 1'b0;
    @(negedge clk);
    chk("stray_no_we_tail", 64'({i_fill_we, d_fill_we}), 64'd0);

    // Random simultaneous request sets; service order follows write > D miss > I miss.
    for (int n = 0; n < 20; n++) begin
      int sel;
      sel = $urandom_range(1, 7);
      lat = $urandom_range(1, 6);
      if (sel[2]) start_w(16'($urandom) & 16'hFFFE, 16'($urandom));
      if (sel[1]) start_d(16'($urandom));
      if (sel[0]) start_i(16'($urandom));
      drain("random");
    end

`ifdef MEM_FILL_PERF_CNT_EN
    chk("i_fill_cnt", 64'(i_fill_cnt), 64'(exp_icnt));
    chk("d_fill_cnt", 64'(d_fill_cnt), 64'(exp_dcnt));
    chk("wr_cnt", 64'(wr_cnt), 64'(exp_wcnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
